counter_multimode_param: RTL
============================

// Module: counter_multimode_param
// PURPOSE
//  Parametrised 4-mode synchronous counter: up-by-STEP, down-by-1, up-by-1, parallel load.
//  Generalises the 4-bit multimode counter to WIDTH bits with a configurable step.
//  Holds its count while disabled and provides a cascade carry chain (CI/CO).
//  Used standalone or chained for wide timing-path counters in the verification testbenches.
// PARAMETERS
//  WIDTH  4  counter width in bits; legal range 2..32
//  STEP   3  increment applied in mode 2'b00; legal range 1..(2**WIDTH-1)
// PORTS
//  clk     in   1      rising-edge clock
//  RESET   in   1      reset: synchronous, active-high
//  ENABLE  in   1      count/load enable
//  CI      in   1      cascade carry-in; tie to 1 on the first stage
//  MODO    in   2      00 up+STEP, 01 down-1, 10 up+1, 11 load D
//  D       in   WIDTH  parallel load data
//  Q       out  WIDTH  count value (registered)
//  RCO     out  1      registered ripple-carry: wrap/borrow occurred on the last edge
//  LOAD    out  1      registered: load performed on the last edge
//  CO      out  1      combinational cascade carry-out to the next stage's CI
// BEHAVIOUR
//  - All state updates on posedge clk. RESET has priority over every other input:
//    cnt=0, RCO=0, LOAD=0.
//  - Internal register cnt[WIDTH-1:0]; Q is driven from cnt (see CONFIGURATION).
//  - adv = ENABLE & CI applies to modes 00/01/10. Mode 11 needs only ENABLE (CI ignored).
//  - wrap condition, evaluated on the current cnt:
//      00: cnt + STEP > 2**WIDTH-1 (computed at WIDTH+1 bits)
//      01: cnt == 0
//      10: cnt == 2**WIDTH-1
//      11: never
//  - All arithmetic is modulo 2**WIDTH; the carry or borrow is discarded into RCO only.
//  - ENABLE=1, mode 00/01/10, CI=1:
//      cnt <= cnt +STEP / -1 / +1
//      RCO <= wrap
//      LOAD <= 0
//  - ENABLE=1, mode 00/01/10, CI=0: cnt holds, RCO <= 0, LOAD <= 0.
//  - ENABLE=1, mode 11: cnt <= D, LOAD <= 1, RCO <= 0.
//  - ENABLE=0: cnt holds, RCO <= 0, LOAD <= 0.
//  - RCO and LOAD are one-cycle pulses per event. Back-to-back wraps give RCO high
//    on consecutive cycles.
//  - CO = ENABLE & CI & wrap & (MODO != 2'b11); purely combinational.
//    Chained stages therefore step in the same cycle. No combinational path from CO to RCO.
//  - Latency: 1 cycle from an input change to Q/RCO/LOAD; 0 cycles to CO.
//  - MODO change mid-count takes effect on the next edge with no transition cycle.
//    D is sampled only when loading.
//  - RESET asserted mid-operation clears state on that edge; counting resumes from 0
//    on the first edge after RESET deasserts.
//  - Elaboration check ($error) when WIDTH or STEP is out of range.
// CONFIGURATION
//  COUNTER_HIZ_EN defined:
//    - While RESET=0 & ENABLE=0, Q = {WIDTH{1'bz}} (legacy shared-bus mode).
//    - cnt still holds internally; Q shows cnt again in the cycle ENABLE returns to 1,
//      combinationally from ENABLE.
//  COUNTER_HIZ_EN undefined:
//    - Q = cnt at all times; never Z or X after the first reset.
// TESTING (WIDTH=4, STEP=3 unless stated)
//  1. RESET=1 for one edge from X state
//     -> Q=0, RCO=0, LOAD=0; CO=0 while ENABLE=0.
//  2. ENABLE=1, MODO=11, D=13 -> Q=13, LOAD=1.
//     Then MODO=00 -> Q=0, RCO=1, LOAD=0.
//     Next edge -> Q=3, RCO=0.
//  3. Q=1, MODO=01 -> Q=0, RCO=0. Next edge -> Q=15, RCO=1.
//     CO=1 combinationally while Q=0, CI=1.
//  4. Two stages chained (CO->CI), MODO=10, stage0=15, stage1=2
//     -> one edge gives stage0=0, stage1=3, stage0 RCO=1; CI=0 on stage0 freezes both.
//  5. Q=5, ENABLE=0 for 3 edges -> Q stays 5, RCO=LOAD=0. With COUNTER_HIZ_EN: Q=zzzz,
//     then Q=5 when ENABLE=1; one more edge with MODO=10 -> Q=6.
//  6. RESET=1 together with ENABLE=1, MODO=11, D=9 -> Q=0, LOAD=0 (reset wins).
//     WIDTH=8, STEP=100, Q=200, MODO=00 -> Q=44, RCO=1.

Source files
------------

// File: rtl/counter_multimode_param.sv
// Parametrised 4-mode counter (up+STEP, down-1, up+1, load) with a CI/CO cascade chain.
// Optional COUNTER_HIZ_EN tri-states Q while the counter is disabled and not in reset.
module counter_multimode_param #(
   parameter int WIDTH = 4,
   parameter int STEP  = 3
) (
   input  logic             clk,
   input  logic             RESET,
   input  logic             ENABLE,
   input  logic             CI,
   input  logic [1:0]       MODO,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] Q,
   output logic             RCO,
   output logic             LOAD,
   output logic             CO
);

   typedef enum logic [1:0] {
      MODE_STEP = 2'b00,
      MODE_DOWN = 2'b01,
      MODE_UP   = 2'b10,
      MODE_LOAD = 2'b11
   } mode_t;

   localparam logic [WIDTH:0] STEP_EXT = (WIDTH+1)'(STEP);

   if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
      $error("counter_multimode_param: WIDTH %0d outside 2..32", WIDTH);
   end
   if (STEP < 1 || longint'(STEP) > ((longint'(1) << WIDTH) - 1)) begin : g_bad_step
      $error("counter_multimode_param: STEP %0d outside 1..2**WIDTH-1", STEP);
   end

   logic [WIDTH-1:0] cnt;
   logic [WIDTH-1:0] nxt;
   logic [WIDTH:0]   sum;
   logic             wrap;
   logic             adv;

   // The extra sum bit is the carry out of the +STEP mode.
   always_comb begin
      sum  = {1'b0, cnt} + STEP_EXT;
      nxt  = cnt;
      wrap = 1'b0;
      case (mode_t'(MODO))
         MODE_STEP: begin
            nxt  = sum[WIDTH-1:0];
            wrap = sum[WIDTH];
         end
         MODE_DOWN: begin
            nxt  = cnt - WIDTH'(1);
            wrap = (cnt == '0);
         end
         MODE_UP: begin
            nxt  = cnt + WIDTH'(1);
            wrap = (cnt == '1);
         end
         default: begin
            nxt  = cnt;
            wrap = 1'b0;
         end
      endcase
   end

   assign adv = ENABLE & CI & (MODO != MODE_LOAD);
   assign CO  = adv & wrap;

   always_ff @(posedge clk) begin
      if (RESET) begin
         cnt  <= '0;
         RCO  <= 1'b0;
         LOAD <= 1'b0;
      end else begin
         RCO  <= 1'b0;
         LOAD <= 1'b0;
         if (ENABLE && MODO == MODE_LOAD) begin
            cnt  <= D;
            LOAD <= 1'b1;
         end else if (adv) begin
            cnt <= nxt;
            RCO <= wrap;
         end
      end
   end

`ifdef COUNTER_HIZ_EN
   assign Q = (!RESET && !ENABLE) ? {WIDTH{1'bz}} : cnt;
`else
   assign Q = cnt;
`endif

endmodule
